// File: rtl/pp_reduce_acc.sv
// pp_reduce_acc: reduces four Booth partial-product rows plus negation
// carry-ins to a 16-bit signed product and accumulates products into
// signed groups delimited by first/last flags.
//
// Handshake (both ports): a transfer happens on a rising edge where
// valid && ready are both high. in_ready is low only while a finished
// result is waiting (out_valid && !out_ready). In that state the whole
// pipeline freezes. out_acc/out_ovf stay stable until they are taken.
module pp_reduce_acc #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      pp0,
  input  logic [9:0]       pp1,
  input  logic [9:0]       pp2,
  input  logic [9:0]       pp3,
  input  logic             neg0,
  input  logic             neg1,
  input  logic             neg2,
  input  logic             neg3,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  // Constant that cancels the sign-extension encoding of the rows.
  localparam logic [15:0] CORR = 16'h5000;

  logic             advance;
  // S1 registers
  logic             s1_valid, s1_first, s1_last;
  logic [11:0]      s1_pp0;
  logic [9:0]       s1_pp1, s1_pp2, s1_pp3;
  logic [3:0]       s1_neg;
  // S2 registers
  logic             s2_valid, s2_first, s2_last;
  logic [15:0]      s2_sum, s2_carry;
  // S3 / accumulator state
  logic [ACC_W-1:0] acc;
  logic             grp_ovf;
  // Combinational intermediates
  logic [15:0]      t0, t1, t2, t3, tn;
  logic [15:0]      sa, ca, sb, cb, sc, cc;
  logic [15:0]      prod16;
  logic [ACC_W-1:0] prod_ext, acc_base, acc_sum;
  logic             add_ovf, ovf_next;

  // Global stall: everything moves only when no result is blocked.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // S1: capture the beat and its group flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_pp0   <= '0;
      s1_pp1   <= '0;
      s1_pp2   <= '0;
      s1_pp3   <= '0;
      s1_neg   <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      s1_pp0   <= pp0;
      s1_pp1   <= pp1;
      s1_pp2   <= pp2;
      s1_pp3   <= pp3;
      s1_neg   <= {neg3, neg2, neg1, neg0};
    end
  end

  // Align the five operands and reduce them with three 3:2 compressor rows.
  always_comb begin
    t0 = {4'b0000, s1_pp0};
    t1 = {4'b0000, s1_pp1, 2'b00};
    t2 = {2'b00, s1_pp2, 4'b0000};
    t3 = {s1_pp3, 6'b000000};
    tn = {9'b0, s1_neg[3], 1'b0, s1_neg[2], 1'b0, s1_neg[1], 1'b0, s1_neg[0]};
    sa = t0 ^ t1 ^ t2;
    ca = {((t0[14:0] & t1[14:0]) | (t0[14:0] & t2[14:0]) | (t1[14:0] & t2[14:0])), 1'b0};
    sb = sa ^ ca ^ t3;
    cb = {((sa[14:0] & ca[14:0]) | (sa[14:0] & t3[14:0]) | (ca[14:0] & t3[14:0])), 1'b0};
    sc = sb ^ cb ^ tn;
    cc = {((sb[14:0] & cb[14:0]) | (sb[14:0] & tn[14:0]) | (cb[14:0] & tn[14:0])), 1'b0};
  end

  // S2: register the carry-save pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_sum   <= '0;
      s2_carry <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_sum   <= sc;
      s2_carry <= cc;
    end
  end

  // Final add, correction, sign extension and signed-overflow detection.
  always_comb begin
    prod16   = s2_sum + s2_carry + CORR;
    prod_ext = ACC_W'($signed(prod16));
    acc_base = s2_first ? '0 : acc;
    acc_sum  = acc_base + prod_ext;
    add_ovf  = (acc_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (acc_sum[ACC_W-1] != acc_base[ACC_W-1]);
    ovf_next = (s2_first ? 1'b0 : grp_ovf) | add_ovf;
  end

  // S3: accumulate, publish on last beat, and manage the result handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      grp_ovf   <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      if (s2_valid) begin
        if (s2_last) begin
          acc     <= '0;
          grp_ovf <= 1'b0;
          out_acc <= acc_sum;
          out_ovf <= ovf_next;
        end else begin
          acc     <= acc_sum;
          grp_ovf <= ovf_next;
        end
      end
      if (s2_valid && s2_last) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pp_reduce_acc.md
PP_REDUCE_ACC -- requirements
Module: pp_reduce_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 24, accumulator width in bits; legal range 16..32.
REQ-002 SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  partial-product beat valid.
REQ-006 SHALL have port in_ready  output  1  beat accepted on an edge where in_valid && in_ready.
REQ-007 SHALL have port pp0  input  12  Booth row 0, already sign-extension encoded.
REQ-008 SHALL have ports pp1, pp2, pp3  input  10 each  Booth rows 1..3, weighted 2^2, 2^4, 2^6.
REQ-009 SHALL have ports neg0..neg3  input  1 each  negation carry-ins, weighted 2^0, 2^2, 2^4, 2^6.
REQ-010 SHALL have port in_first  input  1  beat starts a new accumulation group.
REQ-011 SHALL have port in_last  input  1  beat closes the current group.
REQ-012 SHALL have port out_valid  output  1  group result available.
REQ-013 SHALL have port out_ready  input  1  consumer takes the result on an edge where out_valid && out_ready.
REQ-014 SHALL have port out_acc  output  ACC_W  signed group sum.
REQ-015 SHALL have port out_ovf  output  1  sticky signed-overflow flag for the group.

Function
REQ-016 SHALL compute each product, modulo 2^16, as: pp0 + (pp1<<2) + (pp2<<4) + (pp3<<6) + neg0 + (neg1<<2) + (neg2<<4) + (neg3<<6) + 16'h5000.
REQ-017 SHALL interpret that 16-bit product as signed and sign-extend it to ACC_W.
REQ-018 SHALL be a 3-stage pipeline, each stage with its own valid bit:
  - S1: register all inputs and the first/last flags.
  - S2: carry-save reduce to a registered sum/carry pair, 16 bits each.
  - S3: final add, correction constant, accumulate.
REQ-019 SHALL, for a beat accepted at edge t, register S1 at t, S2 at t+1 and update the accumulator at t+2.
REQ-020 SHALL, for a last beat accepted at edge t, load out_acc/out_ovf and raise out_valid at edge t+2.
REQ-021 SHALL accumulate as: acc_next = (first ? 0 : acc) + prod, wrapping modulo 2^ACC_W.
REQ-022 SHALL set the group overflow flag when that addition overflows in signed arithmetic; the flag is sticky until the group ends.
REQ-023 SHALL, on a last beat, present the group sum on out_acc and the sticky flag on out_ovf, then clear the internal acc and flag to 0.
REQ-024 SHALL treat a beat with both first and last set as a one-product group.
REQ-025 SHALL treat a beat without first that follows a last as starting from acc = 0.
REQ-026 SHALL drive in_ready = !(out_valid && !out_ready), combinationally.
REQ-027 SHALL freeze all stage registers, valids and the accumulator while out_valid && !out_ready (global stall).
REQ-028 SHALL hold out_acc and out_ovf stable while out_valid && !out_ready.
REQ-029 SHALL deassert out_valid on a take when no last beat completes in S3 on that edge.
REQ-030 SHALL, when a take and an S3 last completion fall on the same edge, reload out_acc/out_ovf and keep out_valid high.
REQ-031 SHALL pass bubbles (stage valid = 0) through without changing acc or out_valid.

Reset
REQ-032 SHALL, on reset assertion at any time including mid-group or mid-stall, immediately clear all stage valids, acc, the sticky flag, out_valid, out_acc and out_ovf to 0.
REQ-033 SHALL drive in_ready = 1 while reset is asserted and immediately after reset.
REQ-034 SHALL discard any partially accumulated group on reset and produce no output for it.

Verification
(pp and neg stimulus is generated by the upstream Booth partial-product generator from operands a, b.)
REQ-035 SHALL cover: reset asserted mid-stream -> out_valid=0, out_acc=0, out_ovf=0, in_ready=1 during reset and on the next cycle.
REQ-036 SHALL cover: one beat a=-128, b=-128, first=last=1, accepted at edge t -> out_valid=1 after edge t+2, out_acc=24'h004000, out_ovf=0.
REQ-037 SHALL cover: four back-to-back beats a=127, b=-128 (first on beat 1, last on beat 4) -> a single result out_acc=24'hFF0200, out_ovf=0.
REQ-038 SHALL cover: two consecutive one-beat groups (3x5, then -7x9) with out_ready=0 for 5 cycles -> in_ready=0 while stalled, out_acc held at 15, then results 15 and -63 delivered in order, none lost.
REQ-039 SHALL cover: ACC_W=16, two beats of -128 x -128 in one group -> out_acc=16'h8000, out_ovf=1; the next group 1x1 -> out_acc=1, out_ovf=0.
REQ-040 SHALL cover: exhaustive a, b in [-128, 127], one beat per group, random out_ready -> every out_acc equals sign-extended a*b, results in issue order.
